instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Front-end stage directly upstream of the control unit.
- Holds the program counter and fetches one 32-bit instruction at a time from instruction memory over a req/ready handshake.
- Presents the instruction, with a valid flag, to the control unit and datapath.
- Selects the next PC from the pcsrc control (0 = branch, 1 = next), sampled when the datapath signals completion. It also counts retired instructions and halts on ECALL or an all-zero word.

Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  32  byte address of the fetch; equals pc.
- imem_ready  input  1  memory returns data this cycle; imem_rdata is valid.
- imem_rdata  input  32  fetched instruction word.
- instr  output  32  registered instruction driven to the control unit and datapath.
- instr_pc  output  32  address of instr.
- instr_valid  output  1  instr is valid and is being executed.
- pcsrc  input  1  from the control unit: 0 = take branch, 1 = next sequential.
- branch_off  input  32  signed byte offset (B-immediate) from the datapath.
- ex_done  input  1  datapath finished instr; pcsrc and branch_off are valid this cycle.
- halted  output  1  fetch stopped on ECALL or zero instruction.
- misalign  output  1  sticky flag: a branch target had bits[1:0] != 0.
- retired  output  CNT_W  count of completed instructions.

Behaviour:
- Reset (rst low, asynchronous, takes effect immediately in any state):
  - state = S_RESET, pc = RESET_PC.
  - imem_req = 0, instr = 32'h0000_0013 (NOP), instr_pc = RESET_PC, instr_valid = 0.
  - halted = 0, misalign = 0, retired = 0.
  - Asserting reset mid-fetch drops imem_req immediately. Any in-flight memory response is ignored.
- FSM states: S_RESET, S_FETCH, S_ISSUE, S_HALT.
- S_RESET:
  - First rising edge with rst high moves to S_FETCH.
- S_FETCH:
  - imem_req = 1 and imem_addr = pc, combinationally from state; instr_valid = 0.
  - On an edge with imem_ready = 1:
    - If imem_rdata == 32'h0000_0073 or 32'h0000_0000: go to S_HALT. instr is loaded with the word and instr_pc = pc.
    - Otherwise: instr <= imem_rdata, instr_pc <= pc, go to S_ISSUE.
  - Minimum latency is 1 cycle (ready returned in the first request cycle). There is no timeout; the block waits indefinitely.
  - ex_done is ignored in this state.
- S_ISSUE:
  - imem_req = 0 and instr_valid = 1; instr is held stable.
  - imem_ready is ignored.
  - On an edge with ex_done = 1:
    - retired <= retired + 1, wrapping modulo 2^CNT_W.
    - If pcsrc = 1: pc <= pc + 4.
    - If pcsrc = 0: target = pc + branch_off (32-bit, wraps modulo 2^32). pc <= {target[31:2], 2'b00}. misalign <= misalign | (target[1:0] != 0).
    - Go to S_FETCH.
  - While ex_done = 0, remain in S_ISSUE.
- S_HALT:
  - halted = 1, imem_req = 0, instr_valid = 0.
  - retired is not incremented for the halting instruction.
  - The block stays in S_HALT until reset; all inputs are ignored.
- Arithmetic: PC adders are 32-bit unsigned with wrap. 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- misalign is sticky until reset. The masked target is still used.
- Throughput: at most one instruction per 2 cycles (fetch cycle + issue cycle).
- All outputs are registered except imem_req, imem_addr, instr_valid and halted, which decode state and pc.

Test Plan:
- Reset release with RESET_PC = 0, memory ready in the same cycle returning 32'h0050_0093 (addi) → imem_addr = 0. The next cycle shows instr_valid = 1, instr = 32'h0050_0093, instr_pc = 0. ex_done with pcsrc = 1 → next imem_addr = 4, retired = 1.
- Branch taken: instr_pc = 32'h10, ex_done with pcsrc = 0 and branch_off = -8 → next imem_addr = 32'h08.
- Second branch case: branch_off = 6 → imem_addr = 32'h14 and misalign = 1; misalign stays 1 through later instructions.
- Memory wait states: imem_ready held low for 5 cycles → imem_req stays 1 and imem_addr stays stable, instr_valid = 0. The word is captured on the cycle ready is high.
- Issue hold: ex_done delayed for 4 cycles → instr and instr_pc stable and imem_req = 0 throughout. Asserting imem_ready during S_ISSUE has no effect.
- Halt on fetch of 32'h0000_0073 → halted = 1, imem_req = 0 permanently, retired unchanged.
- Reset pulse mid-fetch at pc = 32'h20 → imem_req drops immediately. All outputs return to reset values; after release, the fetch restarts at RESET_PC.
- Wrap: pc = 32'hFFFF_FFFC with pcsrc = 1 → next imem_addr = 32'h0000_0000.

Source files
------------

// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: fetch unit bus to instruction memory and to the control unit/datapath
interface instr_fetch_unit_if #(
  parameter int CNT_W = 32
);
  logic             imem_req;
  logic [31:0]      imem_addr;
  logic             imem_ready;
  logic [31:0]      imem_rdata;
  logic [31:0]      instr;
  logic [31:0]      instr_pc;
  logic             instr_valid;
  logic             pcsrc;
  logic [31:0]      branch_off;
  logic             ex_done;
  logic             halted;
  logic             misalign;
  logic [CNT_W-1:0] retired;

  modport master (
    output imem_req, imem_addr, instr, instr_pc, instr_valid, halted, misalign, retired,
    input  imem_ready, imem_rdata, pcsrc, branch_off, ex_done
  );

  modport slave (
    input  imem_req, imem_addr, instr, instr_pc, instr_valid, halted, misalign, retired,
    output imem_ready, imem_rdata, pcsrc, branch_off, ex_done
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC holder and one-at-a-time instruction fetcher feeding the control unit
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input logic clk,
  input logic rst,
  instr_fetch_unit_if.master bus
);
  typedef enum logic [1:0] {S_RESET, S_FETCH, S_ISSUE, S_HALT} state_t;

  state_t           state_q;
  logic [31:0]      pc_q;
  logic [31:0]      instr_q;
  logic [31:0]      instr_pc_q;
  logic             misalign_q;
  logic [CNT_W-1:0] retired_q;
  logic [31:0]      target;
  logic [31:0]      pc_d;
  logic             stop_word;

  // next PC: sequential step or word-aligned branch target, both wrapping at 2^32
  always_comb begin
    target    = pc_q + bus.branch_off;
    pc_d      = bus.pcsrc ? pc_q + 32'd4 : {target[31:2], 2'b00};
    stop_word = (bus.imem_rdata == 32'h0000_0073) || (bus.imem_rdata == 32'h0000_0000);
  end

  // fetch/issue/halt sequencing with registered instruction, PC, flags and retire count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_RESET;
      pc_q       <= RESET_PC;
      instr_q    <= 32'h0000_0013;
      instr_pc_q <= RESET_PC;
      misalign_q <= 1'b0;
      retired_q  <= '0;
    end else begin
      case (state_q)
        S_RESET: state_q <= S_FETCH;
        S_FETCH: if (bus.imem_ready) begin
          instr_q    <= bus.imem_rdata;
          instr_pc_q <= pc_q;
          state_q    <= stop_word ? S_HALT : S_ISSUE;
        end
        S_ISSUE: if (bus.ex_done) begin
          retired_q  <= retired_q + 1'b1;
          pc_q       <= pc_d;
          misalign_q <= misalign_q | (!bus.pcsrc && target[1:0] != 2'b00);
          state_q    <= S_FETCH;
        end
        default: state_q <= S_HALT;
      endcase
    end
  end

  assign bus.imem_req    = state_q == S_FETCH;
  assign bus.imem_addr   = pc_q;
  assign bus.instr_valid = state_q == S_ISSUE;
  assign bus.halted      = state_q == S_HALT;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.misalign    = misalign_q;
  assign bus.retired     = retired_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed cycle-vector bench for the instruction fetch unit
module tb_instr_fetch_unit;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  instr_fetch_unit_if #(.CNT_W(32)) bus ();

  instr_fetch_unit #(.RESET_PC(32'h0), .CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        rdy;
    logic [31:0] rdata;
    logic        done;
    logic        pcsrc;
    logic [31:0] off;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] ipc;
    logic        halted;
    logic        mis;
    logic [31:0] ret;
  } vec_t;

  vec_t tbl [29];

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", n, a, e);
    end
  endtask

  task automatic drive(input logic rdy, input logic [31:0] rdata, input logic done,
                       input logic pcsrc, input logic [31:0] off);
    bus.imem_ready = rdy;
    bus.imem_rdata = rdata;
    bus.ex_done    = done;
    bus.pcsrc      = pcsrc;
    bus.branch_off = off;
  endtask

  task automatic chk_state(input string n, input logic req, input logic [31:0] addr,
                           input logic valid, input logic [31:0] instr, input logic [31:0] ipc,
                           input logic halted, input logic mis, input logic [31:0] ret);
    chk({n, ".imem_req"}, 32'(bus.imem_req), 32'(req));
    chk({n, ".imem_addr"}, bus.imem_addr, addr);
    chk({n, ".instr_valid"}, 32'(bus.instr_valid), 32'(valid));
    chk({n, ".instr"}, bus.instr, instr);
    chk({n, ".instr_pc"}, bus.instr_pc, ipc);
    chk({n, ".halted"}, 32'(bus.halted), 32'(halted));
    chk({n, ".misalign"}, 32'(bus.misalign), 32'(mis));
    chk({n, ".retired"}, bus.retired, ret);
  endtask

  initial begin
    tbl[0]  = '{1'b1, 32'h0050_0093, 1'b0, 1'b1, 32'h0,        1'b0, 32'h00, 1'b0, 32'h0000_0013, 32'h00, 1'b0, 1'b0, 32'd0};
    tbl[1]  = '{1'b1, 32'h0050_0093, 1'b0, 1'b1, 32'h0,        1'b1, 32'h00, 1'b0, 32'h0000_0013, 32'h00, 1'b0, 1'b0, 32'd0};
    tbl[2]  = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h0,        1'b0, 32'h00, 1'b1, 32'h0050_0093, 32'h00, 1'b0, 1'b0, 32'd0};
    tbl[3]  = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h0,        1'b1, 32'h04, 1'b0, 32'h0050_0093, 32'h00, 1'b0, 1'b0, 32'd1};
    tbl[4]  = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h100,      1'b1, 32'h04, 1'b0, 32'h0050_0093, 32'h00, 1'b0, 1'b0, 32'd1};
    tbl[5]  = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h0,        1'b1, 32'h04, 1'b0, 32'h0050_0093, 32'h00, 1'b0, 1'b0, 32'd1};
    tbl[6]  = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h0,        1'b1, 32'h04, 1'b0, 32'h0050_0093, 32'h00, 1'b0, 1'b0, 32'd1};
    tbl[7]  = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h0,        1'b1, 32'h04, 1'b0, 32'h0050_0093, 32'h00, 1'b0, 1'b0, 32'd1};
    tbl[8]  = '{1'b1, 32'h00A0_0113, 1'b0, 1'b1, 32'h0,        1'b1, 32'h04, 1'b0, 32'h0050_0093, 32'h00, 1'b0, 1'b0, 32'd1};
    tbl[9]  = '{1'b1, 32'h0000_0073, 1'b0, 1'b1, 32'h0,        1'b0, 32'h04, 1'b1, 32'h00A0_0113, 32'h04, 1'b0, 1'b0, 32'd1};
    tbl[10] = '{1'b1, 32'h0000_0073, 1'b0, 1'b1, 32'h0,        1'b0, 32'h04, 1'b1, 32'h00A0_0113, 32'h04, 1'b0, 1'b0, 32'd1};
    tbl[11] = '{1'b1, 32'h0000_0073, 1'b0, 1'b1, 32'h0,        1'b0, 32'h04, 1'b1, 32'h00A0_0113, 32'h04, 1'b0, 1'b0, 32'd1};
    tbl[12] = '{1'b1, 32'h0000_0073, 1'b0, 1'b1, 32'h0,        1'b0, 32'h04, 1'b1, 32'h00A0_0113, 32'h04, 1'b0, 1'b0, 32'd1};
    tbl[13] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h0,        1'b0, 32'h04, 1'b1, 32'h00A0_0113, 32'h04, 1'b0, 1'b0, 32'd1};
    tbl[14] = '{1'b1, 32'h0000_0013, 1'b0, 1'b1, 32'h0,        1'b1, 32'h08, 1'b0, 32'h00A0_0113, 32'h04, 1'b0, 1'b0, 32'd2};
    tbl[15] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h0,        1'b0, 32'h08, 1'b1, 32'h0000_0013, 32'h08, 1'b0, 1'b0, 32'd2};
    tbl[16] = '{1'b1, 32'h0010_0093, 1'b0, 1'b1, 32'h0,        1'b1, 32'h0C, 1'b0, 32'h0000_0013, 32'h08, 1'b0, 1'b0, 32'd3};
    tbl[17] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h0,        1'b0, 32'h0C, 1'b1, 32'h0010_0093, 32'h0C, 1'b0, 1'b0, 32'd3};
    tbl[18] = '{1'b1, 32'hFE00_0CE3, 1'b0, 1'b1, 32'h0,        1'b1, 32'h10, 1'b0, 32'h0010_0093, 32'h0C, 1'b0, 1'b0, 32'd4};
    tbl[19] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'hFFFF_FFF8, 1'b0, 32'h10, 1'b1, 32'hFE00_0CE3, 32'h10, 1'b0, 1'b0, 32'd4};
    tbl[20] = '{1'b1, 32'h0000_0463, 1'b0, 1'b1, 32'h0,        1'b1, 32'h08, 1'b0, 32'hFE00_0CE3, 32'h10, 1'b0, 1'b0, 32'd5};
    tbl[21] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h8,        1'b0, 32'h08, 1'b1, 32'h0000_0463, 32'h08, 1'b0, 1'b0, 32'd5};
    tbl[22] = '{1'b1, 32'h0000_0663, 1'b0, 1'b1, 32'h0,        1'b1, 32'h10, 1'b0, 32'h0000_0463, 32'h08, 1'b0, 1'b0, 32'd6};
    tbl[23] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h6,        1'b0, 32'h10, 1'b1, 32'h0000_0663, 32'h10, 1'b0, 1'b0, 32'd6};
    tbl[24] = '{1'b1, 32'h0010_0093, 1'b0, 1'b1, 32'h0,        1'b1, 32'h14, 1'b0, 32'h0000_0663, 32'h10, 1'b0, 1'b1, 32'd7};
    tbl[25] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h0,        1'b0, 32'h14, 1'b1, 32'h0010_0093, 32'h14, 1'b0, 1'b1, 32'd7};
    tbl[26] = '{1'b1, 32'h0000_0073, 1'b0, 1'b1, 32'h0,        1'b1, 32'h18, 1'b0, 32'h0010_0093, 32'h14, 1'b0, 1'b1, 32'd8};
    tbl[27] = '{1'b1, 32'h0050_0093, 1'b1, 1'b1, 32'h0,        1'b0, 32'h18, 1'b0, 32'h0000_0073, 32'h18, 1'b1, 1'b1, 32'd8};
    tbl[28] = '{1'b1, 32'h0000_0000, 1'b1, 1'b0, 32'h4,        1'b0, 32'h18, 1'b0, 32'h0000_0073, 32'h18, 1'b1, 1'b1, 32'd8};

    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
    repeat (2) @(negedge clk);
    chk_state("reset", 1'b0, 32'h0, 1'b0, 32'h13, 32'h0, 1'b0, 1'b0, 32'd0);
    rst = 1'b1;
    for (int i = 0; i < 29; i++) begin
      drive(tbl[i].rdy, tbl[i].rdata, tbl[i].done, tbl[i].pcsrc, tbl[i].off);
      #1;
      chk_state($sformatf("vec%0d", i), tbl[i].req, tbl[i].addr, tbl[i].valid, tbl[i].instr,
                tbl[i].ipc, tbl[i].halted, tbl[i].mis, tbl[i].ret);
      @(negedge clk);
    end

    rst = 1'b0;
    #1;
    chk_state("halt_reset", 1'b0, 32'h0, 1'b0, 32'h13, 32'h0, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
    @(negedge clk);
    drive(1'b1, 32'h0050_0093, 1'b0, 1'b1, 32'h0);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h20);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
    #1;
    chk_state("at20", 1'b1, 32'h20, 1'b0, 32'h0050_0093, 32'h0, 1'b0, 1'b0, 32'd1);
    @(posedge clk);
    #2;
    drive(1'b1, 32'h0010_0093, 1'b0, 1'b1, 32'h0);
    rst = 1'b0;
    #1;
    chk_state("midfetch_reset", 1'b0, 32'h0, 1'b0, 32'h13, 32'h0, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk_state("restart", 1'b1, 32'h0, 1'b0, 32'h13, 32'h0, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'hFFFF_FFFC);
    #1;
    chk_state("restart_issue", 1'b0, 32'h0, 1'b1, 32'h0010_0093, 32'h0, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    drive(1'b1, 32'h0000_0013, 1'b0, 1'b1, 32'h0);
    #1;
    chk_state("at_top", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0010_0093, 32'h0, 1'b0, 1'b0, 32'd1);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h0);
    @(negedge clk);
    drive(1'b1, 32'h0000_0000, 1'b0, 1'b1, 32'h0);
    #1;
    chk_state("wrap", 1'b1, 32'h0, 1'b0, 32'h0000_0013, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'd2);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h0);
    repeat (2) @(negedge clk);
    chk_state("zero_halt", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
